alu_acc_seq: RTL and testbench
==============================

// Module: alu_acc_seq
// PURPOSE
//  Parametrised successor of the 8-bit accumulator ALU. Accumulator plus CY/Z/S/O flags, generic WIDTH.
//  Ops are accepted through a valid/ready handshake. Adds a multi-cycle shift-add multiply (FSM-sequenced).
//  Sits in the datapath between operand sources (immediate/register file/memory) and the control unit.
// PARAMETERS
//  WIDTH      8   datapath/accumulator width, >= 2
//  RESET_ACC  0   acc_v value loaded on reset
// PORTS
//  clk        in   1      system clock, rising edge
//  rst        in   1      reset, synchronous, active-high
//  data_src   in   2      operand select: 0 immediate, 1 reg_out, 2 mem_out, 3 acc_v
//  immediate  in   WIDTH  immediate operand
//  reg_out    in   WIDTH  register-file operand
//  mem_out    in   WIDTH  memory operand
//  op         in   4      alu_op_e opcode
//  op_valid   in   1      op/operand valid this cycle
//  op_ready   out  1      block can accept an op (1 in IDLE)
//  ce_a       in   1      enables acc_v and Z/S/O update for this op
//  ce_cy      in   1      enables CY update for this op
//  alu_in     out  WIDTH  selected operand (combinational from data_src)
//  acc_v      out  WIDTH  accumulator
//  flag_cy    out  1      carry/borrow
//  flag_z     out  1      zero
//  flag_s     out  1      sign (result MSB)
//  flag_o     out  1      signed overflow
//  op_err     out  1      one-cycle pulse: unsupported op accepted
// BEHAVIOUR
//  - Reset (rst=1 at edge): acc_v=RESET_ACC, all flags 0, op_err=0, FSM->IDLE, multiplier regs cleared.
//    Reset overrides any in-flight op; no late write after reset.
//  - Accept = op_valid && op_ready at rising edge. Ops presented while op_ready=0 are ignored, not queued.
//  - Single-cycle ops write on the accepting edge:
//    NOP, LD, ADD, ADC, SUB, SBB, AND, OR, XOR, NOT, SHL, SHR, ROLC, RORC, CMP.
//  - Write enables:
//    acc_v/Z/S/O: accept && ce_a (CMP and NOP never write acc_v).
//    CY: accept && ce_cy && op affects CY.
//  - Arithmetic is WIDTH-bit modulo.
//    ADD/ADC: CY = carry out. SUB/SBB/CMP: CY = borrow (a < b). O = signed overflow.
//    Logic ops: O=0, CY unchanged. SHL/SHR/ROLC/RORC: 1-bit; CY = bit shifted out; rotates go through CY; O=0.
//    Z = (result == 0), S = result[WIDTH-1]. CMP updates flags from acc_v - alu_in only.
//  - MUL (ALU_MUL_EN defined): FSM IDLE -> MUL -> IDLE.
//    On accept: latch acc_v and alu_in, latch ce_a/ce_cy, cnt = WIDTH-1, op_ready -> 0.
//    In MUL: one bit per edge. On the edge with cnt==0: write the low WIDTH bits to acc_v; CY = |high half; O = 0; return to IDLE.
//    Result is visible WIDTH edges after the accept edge; op_ready is low for exactly WIDTH cycles.
//    Inputs other than rst are ignored during MUL.
//  - op_err: high for the one cycle after an unsupported op is accepted; otherwise 0.
// CONFIGURATION
//  ALU_MUL_EN defined:
//    MUL is executed as above; the FSM and alu_mul_seq are instantiated.
//  ALU_MUL_EN undefined:
//    No FSM. op_ready is tied to 1. MUL is accepted in one cycle; acc_v and flags are unchanged; op_err pulses.
// STRUCTURE
//  Package alu_pkg: alu_op_e (4-bit enum, 16 ops), data_src_e, and the WIDTH-independent constants.
//  Sub-module alu_mul_seq: shift-add engine (multiplicand, multiplier, 2*WIDTH product, counter, start/done).
//    Compiled only under ALU_MUL_EN.
//  Top level holds the operand mux, the combinational single-cycle ALU, the flag logic and the IDLE/MUL FSM.
// TESTING (WIDTH=8)
//  1. Reset: rst=1 for 1 cycle -> acc_v=0x00, all flags 0, op_ready=1, op_err=0.
//  2. LD imm 0x7F, then ADD imm 0x01 (ce_a=1, ce_cy=1) -> acc_v=0x80, S=1, O=1, Z=0, CY=0.
//  3. acc_v=0xFF, ADD imm 0x01 -> acc_v=0x00, Z=1, CY=1; then ADC imm 0x00 -> acc_v=0x01, CY=0.
//     Repeat with ce_a=0 -> acc_v unchanged. Repeat with ce_cy=0 -> CY unchanged.
//  4. MUL acc_v=0x0C by imm 0x0B -> op_ready low 8 cycles, then acc_v=0x84, CY=0.
//     MUL 0x20 by 0x10 -> acc_v=0x00, Z=1, CY=1. Ops offered while op_ready=0 have no effect.
//  5. rst=1 on the 3rd MUL cycle -> next edge acc_v=0x00, op_ready=1, and no write in later cycles.
//  6. ALU_MUL_EN undefined: MUL with acc_v=0x05 -> acc_v stays 0x05, flags unchanged, op_err=1 for exactly 1 cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode/operand-select encodings and op classification helpers for alu_acc_seq.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'd0,
    OP_LD   = 4'd1,
    OP_ADD  = 4'd2,
    OP_ADC  = 4'd3,
    OP_SUB  = 4'd4,
    OP_SBB  = 4'd5,
    OP_AND  = 4'd6,
    OP_OR   = 4'd7,
    OP_XOR  = 4'd8,
    OP_NOT  = 4'd9,
    OP_SHL  = 4'd10,
    OP_SHR  = 4'd11,
    OP_ROLC = 4'd12,
    OP_RORC = 4'd13,
    OP_CMP  = 4'd14,
    OP_MUL  = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    SRC_IMM = 2'd0,
    SRC_REG = 2'd1,
    SRC_MEM = 2'd2,
    SRC_ACC = 2'd3
  } data_src_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_e;

  localparam int OP_W  = 4;
  localparam int SRC_W = 2;

  // Single-cycle ops that write a result into acc_v.
  function automatic logic op_writes_acc(alu_op_e op);
    return !(op == OP_NOP || op == OP_CMP || op == OP_MUL);
  endfunction

  // Single-cycle ops that refresh Z/S/O; MUL updates them from its own completion path.
  function automatic logic op_writes_zso(alu_op_e op);
    return !(op == OP_NOP || op == OP_MUL);
  endfunction

  function automatic logic op_affects_cy(alu_op_e op);
    case (op)
      OP_ADD, OP_ADC, OP_SUB, OP_SBB, OP_CMP,
      OP_SHL, OP_SHR, OP_ROLC, OP_RORC: return 1'b1;
      default:                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiply engine, one multiplier bit per clock; built only when ALU_MUL_EN is defined.
// product is the final value combinationally on the cycle done is high.
`ifdef ALU_MUL_EN
module alu_mul_seq #(
  parameter int WIDTH = 8,
  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     mcand_in,
  input  logic [WIDTH-1:0]     mplier_in,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] step_sum;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  logic               busy;

  assign step_sum = mplier[0] ? (prod + mcand) : prod;
  assign done     = busy && (cnt == '0);
  assign product  = step_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      prod   <= '0;
      mplier <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
    end else if (start) begin
      mcand  <= {{WIDTH{1'b0}}, mcand_in};
      mplier <= mplier_in;
      prod   <= '0;
      cnt    <= CNT_W'(WIDTH - 1);
      busy   <= 1'b1;
    end else if (busy) begin
      prod   <= step_sum;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (cnt == '0) busy <= 1'b0;
      else           cnt  <= cnt - 1'b1;
    end
  end

endmodule
`endif

// File: rtl/alu_acc_seq.sv
// Accumulator ALU with CY/Z/S/O flags and a valid/ready op intake.
// ALU_MUL_EN adds the sequenced MUL; without it MUL is accepted as a no-op and flagged on op_err.
//
// state   | meaning
// ST_IDLE | op_ready=1, single-cycle ops execute on the accepting edge
// ST_MUL  | shift-add multiply in flight, op_ready=0, inputs ignored
module alu_acc_seq
  import alu_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_ACC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       data_src,
  input  logic [WIDTH-1:0] immediate,
  input  logic [WIDTH-1:0] reg_out,
  input  logic [WIDTH-1:0] mem_out,
  input  logic [3:0]       op,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic             ce_a,
  input  logic             ce_cy,
  output logic [WIDTH-1:0] alu_in,
  output logic [WIDTH-1:0] acc_v,
  output logic             flag_cy,
  output logic             flag_z,
  output logic             flag_s,
  output logic             flag_o,
  output logic             op_err
);

  localparam int MSB = WIDTH - 1;

  alu_op_e        op_e;
  logic           accept;
  logic           acc_we;
  logic           zso_we;
  logic           cy_we;
  logic [WIDTH:0] add_ext;
  logic [WIDTH:0] sub_ext;
  logic           add_cin;
  logic           sub_bin;
  logic [WIDTH-1:0] res;
  logic           cy_n;
  logic           o_n;

  assign op_e   = alu_op_e'(op);
  assign accept = op_valid && op_ready;
  assign acc_we = accept && ce_a && op_writes_acc(op_e);
  assign zso_we = accept && ce_a && op_writes_zso(op_e);
  assign cy_we  = accept && ce_cy && op_affects_cy(op_e);

  always_comb begin
    alu_in = immediate;
    case (data_src_e'(data_src))
      SRC_IMM: alu_in = immediate;
      SRC_REG: alu_in = reg_out;
      SRC_MEM: alu_in = mem_out;
      SRC_ACC: alu_in = acc_v;
      default: alu_in = immediate;
    endcase
  end

  // Carry-in / borrow-in only for the extended forms; borrow is the top bit of the wide difference.
  assign add_cin = (op_e == OP_ADC) && flag_cy;
  assign sub_bin = (op_e == OP_SBB) && flag_cy;
  assign add_ext = {1'b0, acc_v} + {1'b0, alu_in} + {{WIDTH{1'b0}}, add_cin};
  assign sub_ext = {1'b0, acc_v} - {1'b0, alu_in} - {{WIDTH{1'b0}}, sub_bin};

  always_comb begin
    res  = acc_v;
    cy_n = flag_cy;
    o_n  = 1'b0;
    case (op_e)
      OP_LD:  res = alu_in;
      OP_ADD, OP_ADC: begin
        res  = add_ext[WIDTH-1:0];
        cy_n = add_ext[WIDTH];
        o_n  = (acc_v[MSB] == alu_in[MSB]) && (add_ext[MSB] != acc_v[MSB]);
      end
      OP_SUB, OP_SBB, OP_CMP: begin
        res  = sub_ext[WIDTH-1:0];
        cy_n = sub_ext[WIDTH];
        o_n  = (acc_v[MSB] != alu_in[MSB]) && (sub_ext[MSB] != acc_v[MSB]);
      end
      OP_AND: res = acc_v & alu_in;
      OP_OR:  res = acc_v | alu_in;
      OP_XOR: res = acc_v ^ alu_in;
      OP_NOT: res = ~acc_v;
      OP_SHL: begin
        res  = {acc_v[WIDTH-2:0], 1'b0};
        cy_n = acc_v[MSB];
      end
      OP_SHR: begin
        res  = {1'b0, acc_v[WIDTH-1:1]};
        cy_n = acc_v[0];
      end
      OP_ROLC: begin
        res  = {acc_v[WIDTH-2:0], flag_cy};
        cy_n = acc_v[MSB];
      end
      OP_RORC: begin
        res  = {flag_cy, acc_v[WIDTH-1:1]};
        cy_n = acc_v[0];
      end
      default: ;
    endcase
  end

`ifdef ALU_MUL_EN
  alu_state_e         state;
  logic               mul_start;
  logic               mul_done;
  logic               mul_ce_a;
  logic               mul_ce_cy;
  logic [2*WIDTH-1:0] mul_product;

  assign mul_start = accept && (op_e == OP_MUL);

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .start     (mul_start),
    .mcand_in  (acc_v),
    .mplier_in (alu_in),
    .done      (mul_done),
    .product   (mul_product)
  );
`else
  assign op_ready = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_v     <= RESET_ACC;
      flag_cy   <= 1'b0;
      flag_z    <= 1'b0;
      flag_s    <= 1'b0;
      flag_o    <= 1'b0;
      op_err    <= 1'b0;
`ifdef ALU_MUL_EN
      state     <= ST_IDLE;
      op_ready  <= 1'b1;
      mul_ce_a  <= 1'b0;
      mul_ce_cy <= 1'b0;
`endif
    end else begin
      op_err <= 1'b0;
      if (acc_we) acc_v <= res;
      if (zso_we) begin
        flag_z <= (res == '0);
        flag_s <= res[MSB];
        flag_o <= o_n;
      end
      if (cy_we) flag_cy <= cy_n;
`ifdef ALU_MUL_EN
      case (state)
        ST_IDLE: begin
          if (mul_start) begin
            state     <= ST_MUL;
            op_ready  <= 1'b0;
            mul_ce_a  <= ce_a;
            mul_ce_cy <= ce_cy;
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            if (mul_ce_a) begin
              acc_v  <= mul_product[WIDTH-1:0];
              flag_z <= (mul_product[WIDTH-1:0] == '0);
              flag_s <= mul_product[MSB];
              flag_o <= 1'b0;
            end
            if (mul_ce_cy) flag_cy <= |mul_product[2*WIDTH-1:WIDTH];
            state    <= ST_IDLE;
            op_ready <= 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          op_ready <= 1'b1;
        end
      endcase
`else
      if (accept && (op_e == OP_MUL)) op_err <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_alu_acc_seq.sv
// Scoreboard bench for alu_acc_seq (WIDTH=8); MUL scenarios follow ALU_MUL_EN.
`timescale 1ns/1ps
module tb_alu_acc_seq;
  import alu_pkg::*;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   data_src;
  logic [W-1:0] immediate, reg_out, mem_out;
  logic [3:0]   op;
  logic         op_valid, ce_a, ce_cy;
  logic         op_ready, flag_cy, flag_z, flag_s, flag_o, op_err;
  logic [W-1:0] alu_in, acc_v;

  alu_acc_seq #(.WIDTH(W), .RESET_ACC(8'h00)) dut (
    .clk(clk), .rst(rst), .data_src(data_src), .immediate(immediate),
    .reg_out(reg_out), .mem_out(mem_out), .op(op), .op_valid(op_valid),
    .op_ready(op_ready), .ce_a(ce_a), .ce_cy(ce_cy), .alu_in(alu_in),
    .acc_v(acc_v), .flag_cy(flag_cy), .flag_z(flag_z), .flag_s(flag_s),
    .flag_o(flag_o), .op_err(op_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [1:0]   src;
    logic [W-1:0] val;
    alu_op_e      opc;
    logic         cea;
    logic         cecy;
    logic [W-1:0] e_acc;
    logic [3:0]   e_flg;   // {cy,z,s,o}
  } vec_t;

  vec_t         plan_q[$];
  logic [W-1:0] sb_acc_q[$];
  logic [3:0]   sb_flg_q[$];
  string        sb_nm_q[$];
  int           n_run  = 0;
  int           n_fail = 0;

  function automatic void plan(string n, logic [1:0] s, logic [W-1:0] v, alu_op_e o,
                               logic a, logic c, logic [W-1:0] ea, logic [3:0] ef);
    vec_t x;
    x.name = n; x.src = s; x.val = v; x.opc = o; x.cea = a; x.cecy = c;
    x.e_acc = ea; x.e_flg = ef;
    plan_q.push_back(x);
  endfunction

  // Drives one op for a single edge; the expected result enters the scoreboard as it is driven.
  task automatic drive(input vec_t v);
    data_src  = v.src;
    immediate = ~v.val;
    reg_out   = ~v.val;
    mem_out   = ~v.val;
    case (v.src)
      2'd0:    immediate = v.val;
      2'd1:    reg_out   = v.val;
      2'd2:    mem_out   = v.val;
      default: ;
    endcase
    op = v.opc; ce_a = v.cea; ce_cy = v.cecy; op_valid = 1'b1;
    sb_acc_q.push_back(v.e_acc);
    sb_flg_q.push_back(v.e_flg);
    sb_nm_q.push_back(v.name);
    @(posedge clk); #1;
    op_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [W-1:0] ea; logic [3:0] ef; string nm;
    rst = 1'b1; op_valid = 1'b0; op = OP_NOP; ce_a = 1'b0; ce_cy = 1'b0;
    data_src = 2'd0; immediate = 8'h00; reg_out = 8'h00; mem_out = 8'h00;
    sb_acc_q.push_back(8'h00); sb_flg_q.push_back(4'b0000); sb_nm_q.push_back("reset_state");
    @(posedge clk); #1;
    rst = 1'b0;
    ea = sb_acc_q.pop_front(); ef = sb_flg_q.pop_front(); nm = sb_nm_q.pop_front();
    n_run++;
    if ({acc_v, flag_cy, flag_z, flag_s, flag_o} !== {ea, ef}) begin
      n_fail++;
      $display("FAIL %s: acc=%h cy/z/s/o=%b%b%b%b, expected acc=%h cy/z/s/o=%b",
               nm, acc_v, flag_cy, flag_z, flag_s, flag_o, ea, ef);
    end
    n_run++;
    if (op_ready !== 1'b1 || op_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_handshake: op_ready=%b op_err=%b, expected 1 0", op_ready, op_err);
    end
    data_src = 2'd1; reg_out = 8'h5A; #1;
    n_run++;
    if (alu_in !== 8'h5A) begin
      n_fail++;
      $display("FAIL alu_in_mux: got %h expected 5a", alu_in);
    end
  endtask

  task automatic test_add_flags();
    vec_t v; logic [W-1:0] ea; logic [3:0] ef; string nm;
    plan("ld_7f",     0, 8'h7F, OP_LD,  1, 1, 8'h7F, 4'b0000);
    plan("add_ovf",   0, 8'h01, OP_ADD, 1, 1, 8'h80, 4'b0011);
    plan("ld_ff",     0, 8'hFF, OP_LD,  1, 1, 8'hFF, 4'b0010);
    plan("add_wrap",  0, 8'h01, OP_ADD, 1, 1, 8'h00, 4'b1100);
    plan("adc_cin",   0, 8'h00, OP_ADC, 1, 1, 8'h01, 4'b0000);
    while (plan_q.size() > 0) begin
      v = plan_q.pop_front();
      drive(v);
      ea = sb_acc_q.pop_front(); ef = sb_flg_q.pop_front(); nm = sb_nm_q.pop_front();
      n_run++;
      if ({acc_v, flag_cy, flag_z, flag_s, flag_o} !== {ea, ef}) begin
        n_fail++;
        $display("FAIL %s: acc=%h cy/z/s/o=%b%b%b%b, expected acc=%h cy/z/s/o=%b",
                 nm, acc_v, flag_cy, flag_z, flag_s, flag_o, ea, ef);
      end
    end
  endtask

  task automatic test_ce_gating();
    vec_t v; logic [W-1:0] ea; logic [3:0] ef; string nm;
    plan("ld_ff_b",    0, 8'hFF, OP_LD,  1, 1, 8'hFF, 4'b0010);
    plan("add_ce_a0",  0, 8'h01, OP_ADD, 0, 1, 8'hFF, 4'b1010);
    plan("ld_10",      0, 8'h10, OP_LD,  1, 1, 8'h10, 4'b1000);
    plan("add_ce_cy0", 0, 8'h01, OP_ADD, 1, 0, 8'h11, 4'b1000);
    plan("adc_cy1",    0, 8'h01, OP_ADC, 1, 1, 8'h13, 4'b0000);
    while (plan_q.size() > 0) begin
      v = plan_q.pop_front();
      drive(v);
      ea = sb_acc_q.pop_front(); ef = sb_flg_q.pop_front(); nm = sb_nm_q.pop_front();
      n_run++;
      if ({acc_v, flag_cy, flag_z, flag_s, flag_o} !== {ea, ef}) begin
        n_fail++;
        $display("FAIL %s: acc=%h cy/z/s/o=%b%b%b%b, expected acc=%h cy/z/s/o=%b",
                 nm, acc_v, flag_cy, flag_z, flag_s, flag_o, ea, ef);
      end
    end
  endtask

  task automatic test_logic_shift();
    vec_t v; logic [W-1:0] ea; logic [3:0] ef; string nm;
    plan("and_imm",   0, 8'h01, OP_AND,  1, 1, 8'h01, 4'b0000);
    plan("xor_reg",   1, 8'h01, OP_XOR,  1, 1, 8'h00, 4'b0100);
    plan("or_mem",    2, 8'h80, OP_OR,   1, 1, 8'h80, 4'b0010);
    plan("shl",       0, 8'h00, OP_SHL,  1, 1, 8'h00, 4'b1100);
    plan("or_81",     0, 8'h81, OP_OR,   1, 1, 8'h81, 4'b1010);
    plan("rolc",      0, 8'h00, OP_ROLC, 1, 1, 8'h03, 4'b1000);
    plan("shr",       0, 8'h00, OP_SHR,  1, 1, 8'h01, 4'b1000);
    plan("rorc_a",    0, 8'h00, OP_RORC, 1, 1, 8'h80, 4'b1010);
    plan("rorc_b",    0, 8'h00, OP_RORC, 1, 1, 8'hC0, 4'b0010);
    plan("rolc_b",    0, 8'h00, OP_ROLC, 1, 1, 8'h80, 4'b1010);
    plan("cmp_ovf",   0, 8'h01, OP_CMP,  1, 1, 8'h80, 4'b0001);
    plan("sub_ovf",   0, 8'h01, OP_SUB,  1, 1, 8'h7F, 4'b0001);
    plan("sub_borrow",0, 8'h80, OP_SUB,  1, 1, 8'hFF, 4'b1011);
    plan("sbb",       0, 8'h00, OP_SBB,  1, 1, 8'hFE, 4'b0010);
    plan("not",       0, 8'h00, OP_NOT,  1, 1, 8'h01, 4'b0000);
    plan("nop",       0, 8'h55, OP_NOP,  1, 1, 8'h01, 4'b0000);
    plan("add_acc",   3, 8'h00, OP_ADD,  1, 1, 8'h02, 4'b0000);
    plan("cmp_ce_a0", 0, 8'h03, OP_CMP,  0, 1, 8'h02, 4'b1000);
    while (plan_q.size() > 0) begin
      v = plan_q.pop_front();
      drive(v);
      ea = sb_acc_q.pop_front(); ef = sb_flg_q.pop_front(); nm = sb_nm_q.pop_front();
      n_run++;
      if ({acc_v, flag_cy, flag_z, flag_s, flag_o} !== {ea, ef}) begin
        n_fail++;
        $display("FAIL %s: acc=%h cy/z/s/o=%b%b%b%b, expected acc=%h cy/z/s/o=%b",
                 nm, acc_v, flag_cy, flag_z, flag_s, flag_o, ea, ef);
      end
    end
  endtask

`ifdef ALU_MUL_EN
  task automatic test_mul();
    vec_t v; logic [W-1:0] ea; logic [3:0] ef; string nm; int cyc;
    plan("ld_0c",    0, 8'h0C, OP_LD,  1, 1, 8'h0C, 4'b1000);
    plan("mul_0c0b", 0, 8'h0B, OP_MUL, 1, 1, 8'h84, 4'b0010);
    plan("ld_20",    0, 8'h20, OP_LD,  1, 1, 8'h20, 4'b0000);
    plan("mul_2010", 0, 8'h10, OP_MUL, 1, 1, 8'h00, 4'b1100);
    while (plan_q.size() > 0) begin
      v = plan_q.pop_front();
      drive(v);
      if (v.opc == OP_MUL) begin
        n_run++;
        if (op_ready !== 1'b0 || op_err !== 1'b0) begin
          n_fail++;
          $display("FAIL %s_accept: op_ready=%b op_err=%b, expected 0 0", v.name, op_ready, op_err);
        end
        // Offer a load while busy; it must be dropped.
        data_src = 2'd0; immediate = 8'hAA; op = OP_LD; ce_a = 1'b1; ce_cy = 1'b1; op_valid = 1'b1;
        cyc = 1;
        while (op_ready !== 1'b1 && cyc < 40) begin
          @(posedge clk); #1;
          if (op_ready !== 1'b1) cyc++;
        end
        op_valid = 1'b0;
        n_run++;
        if (cyc != W) begin
          n_fail++;
          $display("FAIL %s_busy_cycles: got %0d expected %0d", v.name, cyc, W);
        end
      end
      ea = sb_acc_q.pop_front(); ef = sb_flg_q.pop_front(); nm = sb_nm_q.pop_front();
      n_run++;
      if ({acc_v, flag_cy, flag_z, flag_s, flag_o} !== {ea, ef}) begin
        n_fail++;
        $display("FAIL %s: acc=%h cy/z/s/o=%b%b%b%b, expected acc=%h cy/z/s/o=%b",
                 nm, acc_v, flag_cy, flag_z, flag_s, flag_o, ea, ef);
      end
    end
  endtask

  task automatic test_mul_reset();
    vec_t v; logic [W-1:0] ea; logic [3:0] ef; string nm; logic bad;
    plan("ld_03", 0, 8'h03, OP_LD, 1, 1, 8'h03, 4'b1000);
    v = plan_q.pop_front();
    drive(v);
    ea = sb_acc_q.pop_front(); ef = sb_flg_q.pop_front(); nm = sb_nm_q.pop_front();
    n_run++;
    if ({acc_v, flag_cy, flag_z, flag_s, flag_o} !== {ea, ef}) begin
      n_fail++;
      $display("FAIL %s: acc=%h cy/z/s/o=%b%b%b%b, expected acc=%h cy/z/s/o=%b",
               nm, acc_v, flag_cy, flag_z, flag_s, flag_o, ea, ef);
    end
    plan("mul_reset", 0, 8'h03, OP_MUL, 1, 1, 8'h00, 4'b0000);
    v = plan_q.pop_front();
    drive(v);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ea = sb_acc_q.pop_front(); ef = sb_flg_q.pop_front(); nm = sb_nm_q.pop_front();
    n_run++;
    if ({acc_v, flag_cy, flag_z, flag_s, flag_o, op_ready} !== {ea, ef, 1'b1}) begin
      n_fail++;
      $display("FAIL %s: acc=%h cy/z/s/o=%b%b%b%b rdy=%b, expected acc=%h cy/z/s/o=%b rdy=1",
               nm, acc_v, flag_cy, flag_z, flag_s, flag_o, op_ready, ea, ef);
    end
    bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (acc_v !== 8'h00 || op_ready !== 1'b1) bad = 1'b1;
    end
    n_run++;
    if (bad) begin
      n_fail++;
      $display("FAIL mul_no_late_write: acc=%h op_ready=%b, expected acc=00 op_ready=1", acc_v, op_ready);
    end
  endtask
`else
  task automatic test_mul_disabled();
    vec_t v; logic [W-1:0] ea; logic [3:0] ef; string nm;
    plan("ld_00",     0, 8'h00, OP_LD,  1, 1, 8'h00, 4'b1100);
    plan("sub_01",    0, 8'h01, OP_SUB, 1, 1, 8'hFF, 4'b1010);
    plan("ld_05",     0, 8'h05, OP_LD,  1, 1, 8'h05, 4'b1000);
    plan("mul_unsup", 0, 8'h03, OP_MUL, 1, 1, 8'h05, 4'b1000);
    while (plan_q.size() > 0) begin
      v = plan_q.pop_front();
      drive(v);
      ea = sb_acc_q.pop_front(); ef = sb_flg_q.pop_front(); nm = sb_nm_q.pop_front();
      n_run++;
      if ({acc_v, flag_cy, flag_z, flag_s, flag_o} !== {ea, ef}) begin
        n_fail++;
        $display("FAIL %s: acc=%h cy/z/s/o=%b%b%b%b, expected acc=%h cy/z/s/o=%b",
                 nm, acc_v, flag_cy, flag_z, flag_s, flag_o, ea, ef);
      end
      n_run++;
      if (op_err !== (v.opc == OP_MUL) || op_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL %s_op_err: op_err=%b op_ready=%b, expected %b 1",
                 nm, op_err, op_ready, v.opc == OP_MUL);
      end
    end
    @(posedge clk); #1;
    n_run++;
    if (op_err !== 1'b0) begin
      n_fail++;
      $display("FAIL op_err_pulse_width: op_err=%b expected 0", op_err);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_add_flags();
    test_ce_gating();
    test_logic_shift();
`ifdef ALU_MUL_EN
    test_mul();
    test_mul_reset();
`else
    test_mul_disabled();
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
